// File: rtl/estagio_busca.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and fills the IF/ID register.
// Redirect beats flush beats stall. Out-of-range or misaligned fetches set a sticky error flag.
module estagio_busca #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             fetch_err,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [32:0]      IMEM_LIMIT = 33'(4 * IMEM_WORDS);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [31:0]      NOP        = 32'h0000_0000;

    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             in_range;
    logic [31:0]      pc_nxt;
    logic [31:0]      instr_nxt;
    logic [31:0]      pc4_nxt;
    logic             valid_nxt;
    logic             err_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign in_range  = {1'b0, pc} < IMEM_LIMIT;

    // Next-state selection in priority order: redirect, flush, stall, normal fetch.
    always_comb begin
        pc_nxt    = pc;
        instr_nxt = if_id_instr;
        pc4_nxt   = if_id_pc4;
        valid_nxt = if_id_valid;
        err_nxt   = fetch_err;
        cnt_nxt   = fetch_count;
        if (redirect) begin
            pc_nxt    = redirect_pc & ~32'h3;
            instr_nxt = NOP;
            valid_nxt = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                err_nxt = 1'b1;
            end
        end else if (flush) begin
            pc_nxt    = pc_plus4;
            instr_nxt = NOP;
            valid_nxt = 1'b0;
        end else if (!stall) begin
            pc_nxt  = pc_plus4;
            pc4_nxt = pc_plus4;
            if (in_range) begin
                instr_nxt = imem_data;
                valid_nxt = 1'b1;
                if (fetch_count != CNT_MAX) begin
                    cnt_nxt = fetch_count + CNT_W'(1);
                end
            end else begin
                instr_nxt = NOP;
                valid_nxt = 1'b0;
                err_nxt   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            if_id_instr <= NOP;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_count <= '0;
        end else begin
            pc          <= pc_nxt;
            if_id_instr <= instr_nxt;
            if_id_pc4   <= pc4_nxt;
            if_id_valid <= valid_nxt;
            fetch_err   <= err_nxt;
            fetch_count <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_estagio_busca.sv
// Bench for estagio_busca: directed scenarios plus random stall/flush/redirect traffic,
// compared each cycle against a behavioural fetch model with a ROM array.
module tb_estagio_busca;

    localparam int unsigned WORDS = 256;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic [31:0] imem_addr, imem_data, if_id_instr, if_id_pc4;
    logic        if_id_valid, fetch_err;
    logic [15:0] fetch_count;

    logic [31:0] imem_addr2, imem_data2, if_id_instr2, if_id_pc42;
    logic        if_id_valid2, fetch_err2;
    logic [1:0]  fetch_count2;

    logic [31:0] rom [WORDS];

    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_err;
    int unsigned m_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_read(input logic [31:0] a);
        if (a < 32'(4 * WORDS)) return rom[a[9:2]];
        return 32'hBAAD_F00D;
    endfunction

    assign imem_data  = rom_read(imem_addr);
    assign imem_data2 = rom_read(imem_addr2);

    estagio_busca #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .fetch_err(fetch_err), .fetch_count(fetch_count)
    );

    estagio_busca #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr2), .imem_data(imem_data2),
        .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_instr(if_id_instr2), .if_id_pc4(if_id_pc42), .if_id_valid(if_id_valid2),
        .fetch_err(fetch_err2), .fetch_count(fetch_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("addr", imem_addr, m_pc);
        check("addr_sat", imem_addr2, m_pc);
        check("instr", if_id_instr, m_instr);
        check("valid", 32'(if_id_valid), 32'(m_valid));
        check("err", 32'(fetch_err), 32'(m_err));
        check("cnt", 32'(fetch_count), (m_cnt > 65535) ? 32'd65535 : m_cnt);
        check("cnt_sat", 32'(fetch_count2), (m_cnt > 3) ? 32'd3 : m_cnt);
        if (m_valid) check("pc4", if_id_pc4, m_pc4);
    endtask

    // One clock with the given controls; the model applies the fetch-stage rules.
    task automatic step(input logic s, input logic f, input logic r, input logic [31:0] rpc);
        stall = s; flush = f; redirect = r; redirect_pc = rpc;
        #1;
        check("addr_pre", imem_addr, m_pc);
        @(posedge clk);
        if (r) begin
            m_pc = rpc & 32'hFFFF_FFFC;
            m_valid = 1'b0; m_instr = 32'h0;
            if (rpc[1:0] != 2'b00) m_err = 1'b1;
        end else if (f) begin
            m_pc = m_pc + 32'd4;
            m_valid = 1'b0; m_instr = 32'h0;
        end else if (!s) begin
            if (m_pc < 32'(4 * WORDS)) begin
                m_instr = rom[m_pc[9:2]];
                m_valid = 1'b1;
                m_cnt++;
            end else begin
                m_instr = 32'h0;
                m_valid = 1'b0;
                m_err = 1'b1;
            end
            m_pc4 = m_pc + 32'd4;
            m_pc = m_pc + 32'd4;
        end
        #1;
        check_all();
        stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", if_id_instr, 32'h0);
        check("rst_pc4", if_id_pc4, 32'h0);
        check("rst_valid", 32'(if_id_valid), 32'h0);
        check("rst_err", 32'(fetch_err), 32'h0);
        check("rst_cnt", 32'(fetch_count), 32'h0);
        check("rst_cnt_sat", 32'(fetch_count2), 32'h0);
        stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
    endtask

    initial begin
        rom[0] = 32'h2421_0005;
        rom[1] = 32'h2442_000A;
        rom[2] = 32'h0022_1821;
        rom[3] = 32'h0041_2023;
        for (int i = 4; i < int'(WORDS); i++) rom[i] = $urandom;

        #7;
        do_reset();
        check_all();

        // Straight-line fetch of the first four words, counter saturating in the narrow copy.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t1_instr", if_id_instr, 32'h0041_2023);
        check("t1_pc4", if_id_pc4, 32'h10);
        check("t1_cnt", 32'(fetch_count), 32'd4);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t6_sat", 32'(fetch_count2), 32'd3);

        // Stall while IF/ID holds 2442000A, then resume.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("t2_hold", if_id_instr, 32'h2442_000A);
        check("t2_pc", imem_addr, 32'h8);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t2_next", if_id_instr, 32'h0022_1821);

        // Redirect to 0 with stall asserted at PC=C.
        step(1'b1, 1'b0, 1'b1, 32'h0);
        check("t3_pc", imem_addr, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t3_instr", if_id_instr, 32'h2421_0005);
        check("t3_pc4", if_id_pc4, 32'h4);

        // Flush at PC=4.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t4_valid", 32'(if_id_valid), 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t4_instr", if_id_instr, 32'h0022_1821);

        // Misaligned then out-of-range redirect.
        step(1'b0, 1'b0, 1'b1, 32'h0000_0006);
        check("t5_pc", imem_addr, 32'h4);
        check("t5_err", 32'(fetch_err), 32'h1);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0400);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t5_oor_valid", 32'(if_id_valid), 32'h0);
        check("t5_oor_pc", imem_addr, 32'h404);

        // Wrap of PC through zero.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_pc", imem_addr, 32'h0);

        // Random traffic with occasional resets.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int unsigned sel;
            logic [31:0] tgt;
            sel = $urandom_range(0, 99);
            if (sel < 3) begin
                do_reset();
            end else begin
                case ($urandom_range(0, 3))
                    0: tgt = 32'($urandom_range(0, 1100));
                    1: tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                    default: tgt = 32'($urandom_range(0, 255)) << 2;
                endcase
                step(sel < 28, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), tgt);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
